knap_search_ctrl: RTL and testbench
===================================

Name: knap_search_ctrl

Overview:
- Sequential controller that drives the combinational knapsack subset checker. It enumerates item-selection vectors in ascending binary order and feeds each one to the checker.
- Collects the checker's valid verdicts and reports the lowest-index valid selection.
- Sits between the host/start logic and the checker. It supports a pipelined checker of fixed latency.

Parameters:
- N, 13, number of items (width of the selection vector).
- CHK_LAT, 1, checker response latency in cycles (legal 0..4); verdict for a candidate issued in cycle t arrives in cycle t+CHK_LAT.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a search; honoured only in IDLE.
- abort  input  1  cancel the search in progress.
- cand  output  N  candidate selection vector to checker, bit i = item i selected.
- cand_vld  output  1  cand is a live issue this cycle.
- chk_valid  input  1  checker verdict for the candidate issued CHK_LAT cycles earlier.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse on search completion (not on abort).
- found  output  1  a valid selection was found by the last completed search.
- solution  output  N  lowest-index valid selection; 0 if none.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - cand=0, cand_vld=0, busy=0, done=0, found=0, solution=0.
  - In-flight pipeline tags are cleared.
  - Reset mid-search discards all progress.
- States are IDLE, SCAN and DONE.
- IDLE:
  - start=1 and abort=0 → next cycle SCAN, issue counter=0, found/solution cleared.
  - start=1 and abort=1 together → start ignored.
- SCAN, issuing:
  - Each cycle drive cand=counter and cand_vld=1, then counter+1.
  - The issue phase ends after candidate 2^N-1 is issued. An issue-done flag is used, never counter wrap; no candidate is issued twice.
  - After the issue phase ends, cand_vld=0 and cand holds its last value.
- SCAN, response tracking:
  - A CHK_LAT-deep shift register carries (vld, cand) tags alongside the checker.
  - chk_valid is qualified only when the emerging tag vld=1.
  - CHK_LAT=0: chk_valid is sampled combinationally in the issue cycle.
- First qualified hit:
  - solution ← tag cand and found ← 1.
  - Issuing stops immediately; younger in-flight tags are flushed and ignored.
  - Next state DONE.
- No hit:
  - When the tag for 2^N-1 returns with no hit, found stays 0 → DONE.
- Ordering: responses return in issue order, so the first hit is always the lowest-index valid selection.
- DONE: done=1 for exactly one cycle, then IDLE. found/solution hold until the next accepted start or rst.
- Abort:
  - abort=1 in SCAN → IDLE next cycle.
  - found=0, solution=0, no done pulse, pipeline flushed.
  - abort in IDLE or DONE has no effect.
- start while busy or in DONE is ignored.
- Latency, for start sampled at cycle 0:
  - Candidate k is issued at cycle 1+k.
  - Its verdict is sampled at 1+k+CHK_LAT.
  - done is high at cycle 2+k+CHK_LAT.
  - Full miss: done at cycle 2+(2^N-1)+CHK_LAT.

Optional Feature:
- Macro: KNAP_SOLN_COUNT_EN.
- Defined:
  - Search never stops early; all 2^N candidates are swept.
  - Adds output sol_count [N:0], which counts qualified hits. It is cleared on accepted start, rst or abort, and holds after done.
  - solution is still the lowest-index hit and found = (sol_count!=0).
  - done timing is always the full-miss timing.
- Undefined: stop-at-first-hit behaviour as above; sol_count port and counter absent.

Test Plan:
- N=13, CHK_LAT=1, model valid iff cand==13'h0123; start at cycle 0 → done at cycle 294, found=1, solution=13'h0123, busy low at 294.
- N=13, CHK_LAT=1, model never valid → cand_vld high cycles 1..8192; done at cycle 8194, found=0, solution=0; no cand repeats.
- Model valid for cand 13'h0005 and 13'h0003 → solution=13'h0003, found=1; the hit at 0x0005 is never reported.
- CHK_LAT=0, valid iff cand==0 → done at cycle 2, solution=0, found=1. A second start pulse at cycle 1 is ignored and causes no restart.
- Abort at cycle 100 during a miss sweep → busy=0 at 101, done never pulses, found=0. A subsequent start restarts cand at 0.
- KNAP_SOLN_COUNT_EN, CHK_LAT=2, valid iff popcount(cand)==1 → done at cycle 8195, sol_count=13, solution=13'h0001, found=1.

Source files
------------

// File: rtl/knap_search_if.sv
// Handshake bundle between the knapsack search controller, its host and the
// subset checker. The master side is the controller; the slave side is the
// host/checker pair that drives start/abort and returns verdicts.
// Optional feature macro: KNAP_SOLN_COUNT_EN adds the sol_count signal.
interface knap_search_if #(
    parameter int N = 13
);
    logic         start;
    logic         abort;
    logic [N-1:0] cand;
    logic         cand_vld;
    logic         chk_valid;
    logic         busy;
    logic         done;
    logic         found;
    logic [N-1:0] solution;
`ifdef KNAP_SOLN_COUNT_EN
    logic [N:0]   sol_count;

    modport master (
        input  start, abort, chk_valid,
        output cand, cand_vld, busy, done, found, solution, sol_count
    );
    modport slave (
        output start, abort, chk_valid,
        input  cand, cand_vld, busy, done, found, solution, sol_count
    );
`else
    modport master (
        input  start, abort, chk_valid,
        output cand, cand_vld, busy, done, found, solution
    );
    modport slave (
        output start, abort, chk_valid,
        input  cand, cand_vld, busy, done, found, solution
    );
`endif
endinterface

// File: rtl/knap_search_ctrl.sv
// Knapsack search controller: sweeps selection vectors 0..2^N-1 into a
// pipelined subset checker (latency CHK_LAT, 0..4) and reports the
// lowest-index selection the checker accepts.
// Optional feature macro: KNAP_SOLN_COUNT_EN -- sweep all candidates and
// count every accepted selection in sol_count.
module knap_search_ctrl #(
    parameter int N       = 13,
    parameter int CHK_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    knap_search_if.master bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [N-1:0] LAST_CAND = '1;

    state_t       state_q, state_d;
    logic [N-1:0] cand_q;
    logic         issue_done_q;
    logic         found_q;
    logic [N-1:0] solution_q;
    logic         emerg_vld;
    logic [N-1:0] emerg_cand;
    logic         accept;
    logic         hit;
    logic         last_tag;
    logic         early_stop;
    logic         complete;
    logic         flush;

    assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
    assign hit      = emerg_vld && bus.chk_valid;
    assign last_tag = emerg_vld && (emerg_cand == LAST_CAND);

`ifdef KNAP_SOLN_COUNT_EN
    logic [N:0] sol_count_q;
    assign early_stop    = 1'b0;
    assign bus.sol_count = sol_count_q;
`else
    assign early_stop = hit;
`endif

    // Responses return in issue order, so the tag for 2^N-1 is the last one.
    assign complete = early_stop || last_tag;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d  = state_q;
        flush    = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (complete) begin
                    state_d = DONE;
                    flush   = 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue counter, result capture and optional hit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q       <= '0;
            issue_done_q <= 1'b1;
            found_q      <= 1'b0;
            solution_q   <= '0;
`ifdef KNAP_SOLN_COUNT_EN
            sol_count_q  <= '0;
`endif
        end else if (accept) begin
            cand_q       <= '0;
            issue_done_q <= 1'b0;
            found_q      <= 1'b0;
            solution_q   <= '0;
`ifdef KNAP_SOLN_COUNT_EN
            sol_count_q  <= '0;
`endif
        end else if (state_q == SCAN) begin
            if (bus.abort) begin
                issue_done_q <= 1'b1;
                found_q      <= 1'b0;
                solution_q   <= '0;
`ifdef KNAP_SOLN_COUNT_EN
                sol_count_q  <= '0;
`endif
            end else begin
                if (hit && !found_q) begin
                    solution_q <= emerg_cand;
                    found_q    <= 1'b1;
                end
`ifdef KNAP_SOLN_COUNT_EN
                if (hit) sol_count_q <= sol_count_q + 1'b1;
`endif
                // The done flag, not counter wrap, ends issuing; cand holds.
                if (complete) begin
                    issue_done_q <= 1'b1;
                end else if (!issue_done_q) begin
                    if (cand_q == LAST_CAND) issue_done_q <= 1'b1;
                    else                     cand_q       <= cand_q + 1'b1;
                end
            end
        end
    end

    assign bus.cand     = cand_q;
    assign bus.cand_vld = (state_q == SCAN) && !issue_done_q;
    assign bus.found    = found_q;
    assign bus.solution = solution_q;

    generate
        if (CHK_LAT == 0) begin : g_comb_tag
            assign emerg_vld  = bus.cand_vld;
            assign emerg_cand = cand_q;
        end else begin : g_tag_pipe
            logic [CHK_LAT-1:0] tag_vld_q;
            logic [N-1:0]       tag_cand_q [CHK_LAT];

            // Valid bits of the in-flight tags; cleared on reset and flush.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    tag_vld_q <= '0;
                end else begin
                    tag_vld_q[0] <= bus.cand_vld;
                    for (int i = 1; i < CHK_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
                end
            end

            // Candidate payload of the in-flight tags.
            always_ff @(posedge clk) begin
                // NOTE: the payload array is not reset; it is only read when
                // its valid bit, which is reset, is set.
                tag_cand_q[0] <= cand_q;
                for (int i = 1; i < CHK_LAT; i++) tag_cand_q[i] <= tag_cand_q[i-1];
            end

            assign emerg_vld  = tag_vld_q[CHK_LAT-1];
            assign emerg_cand = tag_cand_q[CHK_LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl. Three instances cover CHK_LAT=1,
// CHK_LAT=0 and (with KNAP_SOLN_COUNT_EN) CHK_LAT=2; the bench plays both
// host and checker. Cycle c is the clock period during which the c-th
// rising edge after the start-sampling edge has not yet occurred; start is
// driven in cycle 0 and sampled at its closing edge.
module tb_knap_search_ctrl;
    localparam int N = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_r = 1'b0;
    logic abort_r = 1'b0;
    int   sel  = 1;
    int   mode = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    knap_search_if #(.N(N)) if1 ();
    knap_search_if #(.N(N)) if0 ();

    knap_search_ctrl #(.N(N), .CHK_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    knap_search_ctrl #(.N(N), .CHK_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    assign if1.start = start_r && (sel == 1);
    assign if1.abort = abort_r && (sel == 1);
    assign if0.start = start_r && (sel == 0);
    assign if0.abort = abort_r && (sel == 0);

    // Checker model: which selections the checker accepts, per test mode.
    function automatic logic chk_model(input int m, input logic [N-1:0] c);
        case (m)
            1:       return c == 13'h0123;
            2:       return (c == 13'h0005) || (c == 13'h0003);
            3:       return c == 13'h0000;
            4:       return $countones(c) == 1;
            default: return 1'b0;
        endcase
    endfunction

    logic chk1;
    always @(posedge clk) chk1 <= chk_model(mode, if1.cand);
    assign if1.chk_valid = chk1;
    assign if0.chk_valid = chk_model(mode, if0.cand);

`ifdef KNAP_SOLN_COUNT_EN
    knap_search_if #(.N(N)) if2 ();
    knap_search_ctrl #(.N(N), .CHK_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    assign if2.start = start_r && (sel == 2);
    assign if2.abort = abort_r && (sel == 2);
    logic chk2a, chk2b;
    always @(posedge clk) begin
        chk2a <= chk_model(mode, if2.cand);
        chk2b <= chk2a;
    end
    assign if2.chk_valid = chk2b;
`endif

    // Outputs of the instance under test.
    logic [N-1:0] o_cand, o_solution;
    logic         o_cand_vld, o_busy, o_done, o_found;
    always_comb begin
        o_cand     = if1.cand;
        o_cand_vld = if1.cand_vld;
        o_busy     = if1.busy;
        o_done     = if1.done;
        o_found    = if1.found;
        o_solution = if1.solution;
        if (sel == 0) begin
            o_cand     = if0.cand;
            o_cand_vld = if0.cand_vld;
            o_busy     = if0.busy;
            o_done     = if0.done;
            o_found    = if0.found;
            o_solution = if0.solution;
        end
`ifdef KNAP_SOLN_COUNT_EN
        else if (sel == 2) begin
            o_cand     = if2.cand;
            o_cand_vld = if2.cand_vld;
            o_busy     = if2.busy;
            o_done     = if2.done;
            o_found    = if2.found;
            o_solution = if2.solution;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of the last run.
    int r_done_cyc, r_done_n, r_vld_first, r_vld_last, r_vld_n;
    logic r_seq_ok, r_busy_at_done, r_probe_busy;

    // Start a search on instance s and observe it for ncyc cycles.
    task automatic run(input int s, input int m, input int ncyc,
                       input int abort_at, input int restart_at, input int probe_at);
        sel = s;
        mode = m;
        r_done_cyc = -1; r_done_n = 0; r_vld_first = -1; r_vld_last = -1;
        r_vld_n = 0; r_seq_ok = 1'b1; r_busy_at_done = 1'bx; r_probe_busy = 1'bx;
        @(negedge clk);
        start_r = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start_r = (c == restart_at);
            abort_r = (c == abort_at);
            if (o_cand_vld) begin
                if (r_vld_n == 0) r_vld_first = c;
                r_vld_last = c;
                if ({19'b0, o_cand} != r_vld_n) r_seq_ok = 1'b0;
                r_vld_n++;
            end
            if (o_done) begin
                if (r_done_n == 0) begin
                    r_done_cyc = c;
                    r_busy_at_done = o_busy;
                end
                r_done_n++;
            end
            if (c == probe_at) r_probe_busy = o_busy;
        end
        @(negedge clk);
        start_r = 1'b0;
        abort_r = 1'b0;
    endtask

    initial begin
        // Reset state of both default-build instances.
        repeat (3) @(negedge clk);
        check("rst_busy",  {30'b0, if1.busy, if0.busy}, 32'h0);
        check("rst_done",  {30'b0, if1.done, if0.done}, 32'h0);
        check("rst_found", {30'b0, if1.found, if0.found}, 32'h0);
        check("rst_vld",   {30'b0, if1.cand_vld, if0.cand_vld}, 32'h0);
        check("rst_cand",  {6'b0, if1.cand, if0.cand}, 32'h0);
        check("rst_sol",   {6'b0, if1.solution, if0.solution}, 32'h0);
        rst = 1'b0;

        // Single hit at 0x0123, CHK_LAT=1.
        run(1, 1, 300, -1, -1, -1);
        check("hit_done_cyc",  r_done_cyc, 294);
        check("hit_done_n",    r_done_n, 1);
        check("hit_busy_done", {31'b0, r_busy_at_done}, 0);
        check("hit_found",     {31'b0, o_found}, 1);
        check("hit_solution",  {19'b0, o_solution}, 32'h0123);
        check("hit_seq",       {31'b0, r_seq_ok}, 1);
        check("hit_vld_last",  r_vld_last, 293);

        // Abort in IDLE leaves the result alone.
        @(negedge clk); abort_r = 1'b1;
        @(negedge clk); abort_r = 1'b0;
        @(negedge clk);
        check("idle_abort_found", {31'b0, o_found}, 1);
        check("idle_abort_sol",   {19'b0, o_solution}, 32'h0123);

        // Full miss sweep.
        run(1, 0, 8200, -1, -1, -1);
        check("miss_vld_first", r_vld_first, 1);
        check("miss_vld_last",  r_vld_last, 8192);
        check("miss_vld_n",     r_vld_n, 8192);
        check("miss_seq",       {31'b0, r_seq_ok}, 1);
        check("miss_done_cyc",  r_done_cyc, 8194);
        check("miss_done_n",    r_done_n, 1);
        check("miss_found",     {31'b0, o_found}, 0);
        check("miss_solution",  {19'b0, o_solution}, 0);

        // Two valid selections: the lower index wins.
        run(1, 2, 20, -1, -1, -1);
        check("two_done_cyc", r_done_cyc, 6);
        check("two_found",    {31'b0, o_found}, 1);
        check("two_solution", {19'b0, o_solution}, 32'h0003);

        // CHK_LAT=0, hit on candidate 0, second start in cycle 1 ignored.
        run(0, 3, 30, -1, 1, -1);
        check("lat0_done_cyc", r_done_cyc, 2);
        check("lat0_done_n",   r_done_n, 1);
        check("lat0_vld_n",    r_vld_n, 1);
        check("lat0_found",    {31'b0, o_found}, 1);
        check("lat0_solution", {19'b0, o_solution}, 0);

        // Abort at cycle 100 of a miss sweep.
        run(1, 0, 300, 100, -1, 101);
        check("abort_busy_101", {31'b0, r_probe_busy}, 0);
        check("abort_done_n",   r_done_n, 0);
        check("abort_vld_last", r_vld_last, 100);
        check("abort_found",    {31'b0, o_found}, 0);
        check("abort_solution", {19'b0, o_solution}, 0);

        // Restart after abort begins again at candidate 0.
        run(1, 1, 300, -1, -1, -1);
        check("restart_first", r_vld_first, 1);
        check("restart_seq",   {31'b0, r_seq_ok}, 1);
        check("restart_done",  r_done_cyc, 294);
        check("restart_sol",   {19'b0, o_solution}, 32'h0123);

        // Reset in the middle of a search.
        run(1, 0, 50, -1, -1, -1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'b0, o_busy}, 0);
        check("midrst_vld",  {31'b0, o_cand_vld}, 0);
        check("midrst_cand", {19'b0, o_cand}, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef KNAP_SOLN_COUNT_EN
        // Counting sweep, CHK_LAT=2, hits at every one-hot selection.
        run(2, 4, 8200, -1, -1, -1);
        check("cnt_done_cyc",  r_done_cyc, 8195);
        check("cnt_done_n",    r_done_n, 1);
        check("cnt_sol_count", {18'b0, if2.sol_count}, 13);
        check("cnt_solution",  {19'b0, o_solution}, 32'h0001);
        check("cnt_found",     {31'b0, o_found}, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
